req_initiator: RTL

Requester side of the single-bit req/ack handshake. Takes transaction requests from local logic over a valid/ready port and drives `req` toward a responder. The responder returns a one-cycle `ack` pulse. Holds `req` until `ack`, enforces an idle gap between transactions, times out and retries a silent responder, and reports completion, error and statistics back to local logic.

---
 rtl/req_ack_pkg.sv | 15 +
 rtl/req_initiator.sv | 121 ++++++++++++
 2 files changed

// File: rtl/req_ack_pkg.sv
// Shared definitions for the single-bit req/ack handshake: FSM states and
// default timing used by both the initiator and the responder bench.
package req_ack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } req_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 16;
  localparam int unsigned GAP_DEFAULT     = 1;
  localparam int unsigned RETRIES_DEFAULT = 3;

endpackage

// File: rtl/req_initiator.sv
// Requester side of the req/ack handshake: holds req until ack, inserts an
// idle gap after every attempt, retries on timeout and reports the outcome.
module req_initiator
  import req_ack_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int unsigned MAX_RETRIES    = RETRIES_DEFAULT,
  parameter int unsigned GAP_CYCLES     = GAP_DEFAULT,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  output logic             req,
  input  logic             ack,
  output logic             done,
  output logic             error,
  output logic             spurious_ack,
  output logic [7:0]       retry_cnt,
  output logic [CNT_W-1:0] txn_count
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);

  localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST    = GAP_W'(GAP_CYCLES - 1);
  localparam logic [7:0]         RETRY_LIMIT = 8'(MAX_RETRIES);

  req_state_e         state_q;
  logic               req_q;
  logic               done_q;
  logic               error_q;
  logic               spurious_q;
  logic               timeout_q;
  logic [TIMER_W-1:0] timer_q;
  logic [GAP_W-1:0]   gap_q;
  logic [7:0]         retry_q;
  logic [CNT_W-1:0]   txn_q;

  // NOTE: every register here updates with non-blocking assignments so all of
  // them see the same pre-edge values; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      spurious_q <= 1'b0;
      timeout_q  <= 1'b0;
      timer_q    <= '0;
      gap_q      <= '0;
      retry_q    <= '0;
      txn_q      <= '0;
    end else begin
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      spurious_q <= ack && !req_q;

      case (state_q)
        IDLE: begin
          if (start_valid) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            retry_q <= '0;
            timer_q <= '0;
          end
        end

        // ack is checked before expiry so an ack on the last cycle wins
        REQ: begin
          if (ack) begin
            state_q   <= GAP;
            req_q     <= 1'b0;
            done_q    <= 1'b1;
            txn_q     <= txn_q + CNT_W'(1);
            timeout_q <= 1'b0;
            gap_q     <= '0;
          end else if (timer_q == TIMER_LAST) begin
            state_q   <= GAP;
            req_q     <= 1'b0;
            timeout_q <= 1'b1;
            gap_q     <= '0;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end

        GAP: begin
          if (gap_q != GAP_LAST) begin
            gap_q <= gap_q + GAP_W'(1);
          end else if (!timeout_q) begin
            state_q <= IDLE;
          end else if (retry_q < RETRY_LIMIT) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            retry_q <= retry_q + 8'd1;
            timer_q <= '0;
          end else begin
            // error takes the pulse slot; a coincident stray ack is dropped
            state_q    <= IDLE;
            error_q    <= 1'b1;
            spurious_q <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ready  = (state_q == IDLE) && !rst;
  assign req          = req_q;
  assign done         = done_q;
  assign error        = error_q;
  assign spurious_ack = spurious_q;
  assign retry_cnt    = retry_q;
  assign txn_count    = txn_q;

endmodule
